// File: rtl/audio_pkg.sv
// Shared types for the audio DAC feeder: sample width, stereo pair and FSM state encoding.
package audio_pkg;

  localparam int BITS_DEF = 16;

  typedef logic signed [BITS_DEF-1:0] sample_t;

  typedef struct packed {
    sample_t l;
    sample_t r;
  } stereo_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_PLAY  = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/lrck_edge_sync.sv
// Two-flop synchroniser for the codec LRCK plus a one-cycle pulse on its rising edge.
module lrck_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise_o
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic hist_q,  hist_d;

  always_comb begin
    sync1_d = async_in;
    sync2_d = sync1_q;
    hist_d  = sync2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hist_q  <= hist_d;
    end
  end

  assign rise_o = sync2_q & ~hist_q;

endmodule

// File: rtl/audio_dac_feeder.sv
// Stereo playback FIFO popping one pair per LRCK rise onto the DAC inputs, with prime/underrun/overflow handling.
// Optional build macro AUDIO_FEEDER_VOLUME_EN adds a 4-bit arithmetic-shift attenuator (iVolume).
module audio_dac_feeder
  import audio_pkg::*;
#(
  parameter int BITS  = BITS_DEF,
  parameter int ABITS = 8,
  parameter int PRIME = 128
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iLRCK,
  input  logic              iEnable,
  input  logic              iWrite,
  input  logic [BITS-1:0]   iSampL,
  input  logic [BITS-1:0]   iSampR,
  input  logic              iClrFlags,
`ifdef AUDIO_FEEDER_VOLUME_EN
  input  logic [3:0]        iVolume,
`endif
  output logic              oFull,
  output logic [ABITS:0]    oLevel,
  output logic              oUnderrun,
  output logic              oOverflow,
  output logic              oPlaying,
  output logic [BITS-1:0]   oAUD_outL,
  output logic [BITS-1:0]   oAUD_outR
);

  localparam int             DEPTH     = 1 << ABITS;
  localparam logic [ABITS:0] LVL_FULL  = (ABITS+1)'(DEPTH);
  localparam logic [ABITS:0] LVL_PRIME = (ABITS+1)'(PRIME);

  feeder_state_t     state_q, state_d;
  logic [ABITS-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ABITS-1:0]  rd_ptr_q, rd_ptr_d;
  logic [ABITS:0]    level_q, level_d;
  logic              full_q, full_d;
  logic              unf_q, unf_d;
  logic              ovf_q, ovf_d;
  logic [BITS-1:0]   out_l_q, out_l_d;
  logic [BITS-1:0]   out_r_q, out_r_d;

  logic              tick_s;
  logic              push_ok_s;
  logic              ovf_set_s;
  logic              pop_s;
  logic              unf_set_s;
  logic [2*BITS-1:0] rd_data_s;
  logic [2*BITS-1:0] mem_q [DEPTH];

  function automatic logic [BITS-1:0] attenuate(input logic [BITS-1:0] s, input logic [3:0] sh);
    return BITS'($signed(s) >>> sh);
  endfunction

  lrck_edge_sync u_lrck_sync (
    .clk      (iCLK),
    .rst_n    (iRST_N),
    .async_in (iLRCK),
    .rise_o   (tick_s)
  );

  // Sample storage: no reset, read combinationally at the pop cycle.
  always_ff @(posedge iCLK) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= {iSampL, iSampR};
    end
  end

  assign rd_data_s = mem_q[rd_ptr_q];

  // Playback FSM and output mux; full is sampled before any pop in the same cycle.
  always_comb begin
    push_ok_s = iWrite & ~full_q;
    ovf_set_s = iWrite & full_q;
    pop_s     = 1'b0;
    unf_set_s = 1'b0;
    state_d   = state_q;
    out_l_d   = out_l_q;
    out_r_d   = out_r_q;
    if (!iEnable) begin
      state_d = ST_IDLE;
      out_l_d = '0;
      out_r_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_PRIME;
          out_l_d = '0;
          out_r_d = '0;
        end
        ST_PRIME: begin
          out_l_d = '0;
          out_r_d = '0;
          if (level_q >= LVL_PRIME) begin
            state_d = ST_PLAY;
          end else begin
            state_d = ST_PRIME;
          end
        end
        ST_PLAY: begin
          if (tick_s) begin
            if (level_q == '0) begin
              unf_set_s = 1'b1;
              state_d   = ST_PRIME;
              out_l_d   = '0;
              out_r_d   = '0;
            end else begin
              pop_s = 1'b1;
`ifdef AUDIO_FEEDER_VOLUME_EN
              out_l_d = attenuate(rd_data_s[2*BITS-1:BITS], iVolume);
              out_r_d = attenuate(rd_data_s[BITS-1:0], iVolume);
`else
              out_l_d = attenuate(rd_data_s[2*BITS-1:BITS], 4'd0);
              out_r_d = attenuate(rd_data_s[BITS-1:0], 4'd0);
`endif
            end
          end else begin
            state_d = ST_PLAY;
          end
        end
        default: begin
          state_d = ST_IDLE;
          out_l_d = '0;
          out_r_d = '0;
        end
      endcase
    end
  end

  // Pointers, level counter and sticky flags; clear beats set.
  always_comb begin
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + {{(ABITS-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + {{(ABITS-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_s})
      2'b10:   level_d = level_q + {{ABITS{1'b0}}, 1'b1};
      2'b01:   level_d = level_q - {{ABITS{1'b0}}, 1'b1};
      default: level_d = level_q;
    endcase
    full_d = (level_d == LVL_FULL);
    if (iClrFlags) begin
      unf_d = 1'b0;
      ovf_d = 1'b0;
    end else begin
      unf_d = unf_q | unf_set_s;
      ovf_d = ovf_q | ovf_set_s;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      unf_q    <= 1'b0;
      ovf_q    <= 1'b0;
      out_l_q  <= '0;
      out_r_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      unf_q    <= unf_d;
      ovf_q    <= ovf_d;
      out_l_q  <= out_l_d;
      out_r_q  <= out_r_d;
    end
  end

  assign oFull     = full_q;
  assign oLevel    = level_q;
  assign oUnderrun = unf_q;
  assign oOverflow = ovf_q;
  assign oPlaying  = (state_q == ST_PLAY);
  assign oAUD_outL = out_l_q;
  assign oAUD_outR = out_r_q;

endmodule

// File: tb/tb_audio_dac_feeder.sv
// Randomised bench for audio_dac_feeder against a queue-based playback model.
module tb_audio_dac_feeder;

  logic        iCLK = 1'b0;
  logic        iRST_N = 1'b0;
  logic        iLRCK = 1'b0;
  logic        iEnable = 1'b0;
  logic        iWrite = 1'b0;
  logic [15:0] iSampL = 16'd0;
  logic [15:0] iSampR = 16'd0;
  logic        iClrFlags = 1'b0;
  logic [3:0]  iVolume = 4'd0;
  logic        oFull, oUnderrun, oOverflow, oPlaying;
  logic [8:0]  oLevel;
  logic [15:0] oAUD_outL, oAUD_outR;

  always #5 iCLK = ~iCLK;

  audio_dac_feeder dut (
    .iCLK      (iCLK),
    .iRST_N    (iRST_N),
    .iLRCK     (iLRCK),
    .iEnable   (iEnable),
    .iWrite    (iWrite),
    .iSampL    (iSampL),
    .iSampR    (iSampR),
    .iClrFlags (iClrFlags),
`ifdef AUDIO_FEEDER_VOLUME_EN
    .iVolume   (iVolume),
`endif
    .oFull     (oFull),
    .oLevel    (oLevel),
    .oUnderrun (oUnderrun),
    .oOverflow (oOverflow),
    .oPlaying  (oPlaying),
    .oAUD_outL (oAUD_outL),
    .oAUD_outR (oAUD_outR)
  );

  int total = 0;
  int bad   = 0;

  // Model: FIFO as a queue, playback state as two flags, expected outputs.
  logic [31:0] m_q[$];
  bit          m_play = 1'b0;
  bit          m_unf = 1'b0;
  bit          m_ovf = 1'b0;
  logic [15:0] m_l = 16'd0;
  logic [15:0] m_r = 16'd0;
  logic [3:0]  m_vol = 4'd0;
  int          seq_n = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] vshift(input logic [15:0] v);
    logic signed [15:0] s;
    s = v;
    return 16'(s >>> m_vol);
  endfunction

  task automatic check_all(input string tag);
    check_val({tag, ".outL"},  {16'd0, oAUD_outL}, {16'd0, m_l});
    check_val({tag, ".outR"},  {16'd0, oAUD_outR}, {16'd0, m_r});
    check_val({tag, ".level"}, {23'd0, oLevel}, 32'(m_q.size()));
    check_val({tag, ".full"},  {31'd0, oFull}, {31'd0, (m_q.size() == 256)});
    check_val({tag, ".play"},  {31'd0, oPlaying}, {31'd0, m_play});
    check_val({tag, ".unf"},   {31'd0, oUnderrun}, {31'd0, m_unf});
    check_val({tag, ".ovf"},   {31'd0, oOverflow}, {31'd0, m_ovf});
  endtask

  function automatic void model_push(input logic [15:0] l, input logic [15:0] r, input bit was_full);
    if (was_full) m_ovf = 1'b1;
    else          m_q.push_back({l, r});
  endfunction

  function automatic void model_prime_check();
    if (iEnable && !m_play && m_q.size() >= 128) m_play = 1'b1;
  endfunction

  task automatic push(input logic [15:0] l, input logic [15:0] r);
    @(negedge iCLK);
    iWrite = 1'b1; iSampL = l; iSampR = r;
    @(negedge iCLK);
    iWrite = 1'b0;
    model_push(l, r, m_q.size() == 256);
    model_prime_check();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge iCLK);
  endtask

  task automatic lrck_pulse(input bit push_too, input logic [15:0] pl, input logic [15:0] pr);
    bit was_full;
    @(negedge iCLK);
    iLRCK = 1'b1;
    @(negedge iCLK);
    @(negedge iCLK);
    check_val("latency.outL", {16'd0, oAUD_outL}, {16'd0, m_l});
    if (push_too) begin
      iWrite = 1'b1; iSampL = pl; iSampR = pr;
    end
    was_full = (m_q.size() == 256);
    @(negedge iCLK);
    iWrite = 1'b0;
    iLRCK = 1'b0;
    if (m_play && iEnable) begin
      if (m_q.size() > 0) begin
        logic [31:0] p;
        p = m_q.pop_front();
        m_l = vshift(p[31:16]);
        m_r = vshift(p[15:0]);
      end else begin
        m_unf = 1'b1;
        m_play = 1'b0;
        m_l = 16'd0;
        m_r = 16'd0;
      end
    end
    if (push_too) model_push(pl, pr, was_full);
    idle(2);
    model_prime_check();
  endtask

  initial begin
    // Reset
    idle(2);
    check_all("reset");
    iRST_N = 1'b1;
    idle(2);
    check_all("post_reset");

    // 1: priming threshold
    for (int i = 0; i < 127; i++) push(16'($urandom), 16'($urandom));
    iEnable = 1'b1;
    idle(3);
    for (int i = 0; i < 4; i++) lrck_pulse(1'b0, 16'd0, 16'd0);
    check_all("prime127");
    push(16'($urandom), 16'($urandom));
    idle(2);
    check_all("prime128");

    // 2: steady playback across pointer wrap
    for (int n = 0; n < 200; n++) begin
      push(16'(16'h1000 + n), 16'(-n));
      lrck_pulse(1'b0, 16'd0, 16'd0);
      check_val("play.outL", {16'd0, oAUD_outL}, {16'd0, m_l});
      check_val("play.outR", {16'd0, oAUD_outR}, {16'd0, m_r});
      idle($urandom_range(0, 3));
    end
    check_all("wrap");

    // 3: overflow
    while (m_q.size() < 256) push(16'($urandom), 16'($urandom));
    check_all("full");
    push(16'h7FFF, 16'h7FFF);
    check_all("overflow");

    // 4: drain, then underrun
    while (m_q.size() > 0) begin
      lrck_pulse(1'b0, 16'd0, 16'd0);
      check_val("drain.outL", {16'd0, oAUD_outL}, {16'd0, m_l});
      check_val("drain.outR", {16'd0, oAUD_outR}, {16'd0, m_r});
    end
    lrck_pulse(1'b0, 16'd0, 16'd0);
    check_all("underrun");
    @(negedge iCLK); iClrFlags = 1'b1;
    @(negedge iCLK); iClrFlags = 1'b0;
    m_unf = 1'b0; m_ovf = 1'b0;
    check_all("clrflags");

    // 5: simultaneous push and pop at level 50, then disable
    for (int i = 0; i < 128; i++) push(16'($urandom), 16'($urandom));
    idle(2);
    while (m_q.size() > 50) lrck_pulse(1'b0, 16'd0, 16'd0);
    check_all("level50");
    lrck_pulse(1'b1, 16'($urandom), 16'($urandom));
    check_all("push_pop");
    @(negedge iCLK); iEnable = 1'b0;
    @(negedge iCLK);
    m_play = 1'b0; m_l = 16'd0; m_r = 16'd0;
    check_all("disable");
    lrck_pulse(1'b0, 16'd0, 16'd0);
    check_all("idle_tick");

`ifdef AUDIO_FEEDER_VOLUME_EN
    // 6: attenuation
    iVolume = 4'd2; m_vol = 4'd2;
    iEnable = 1'b1;
    idle(3);
    while (m_q.size() < 127) push(16'($urandom), 16'($urandom));
    push(16'(-8000), 16'h7FFF);
    idle(2);
    while (m_q.size() > 0) lrck_pulse(1'b0, 16'd0, 16'd0);
    check_val("vol.L", {16'd0, oAUD_outL}, {16'd0, 16'(-2000)});
    check_val("vol.R", {16'd0, oAUD_outR}, 32'h0000_1FFF);
    check_all("volume");
`endif

    // Reset mid-stream
    iRST_N = 1'b0;
    #1;
    m_q.delete(); m_play = 1'b0; m_unf = 1'b0; m_ovf = 1'b0; m_l = 16'd0; m_r = 16'd0;
    check_all("async_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
